e_nested_assembler: RTL and testbench

- Receive side of the eNestedSt beat link. The peer transmitter slices one eNestedSt (18 bits) into four tagged beats. Each beat carries an eHeaderSt hdr (2 bits) plus a 7-bit payload.
- This block checks the beat order, reassembles the beats into an eNestedSt, and presents the result on a valid/ready output with a one-entry holding register.
- Sits between the narrow link and the consumer of eNestedSt. Reports sequencing errors.

---
 rtl/e_nested_assembler.sv | 123 ++++++++++++
 tb/tb_e_nested_assembler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_nested_assembler.sv
// e_nested_assembler: receive side of the eNestedSt beat link.
// Checks the A/D/J0/J1 beat order and rebuilds an 18-bit eNestedSt.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   in_valid/in_ready     beat handshake
//   in_hdr[1:0]           beat tag (0=A, 1=D, 2=J0, 3=J1)
//   in_data[6:0]          beat payload
//   out_valid/out_ready   assembled-frame handshake (one-entry hold)
//   out_data[17:0]        {variablea, bob[6:0], joe1[4:0], joe0[4:0]}
//   err_pulse             one cycle after each accepted out-of-order beat
//   err_count             saturating error count
module e_nested_assembler #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_hdr,
  input  logic [6:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [17:0]          out_data,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EXP_A  = 2'd0,
    EXP_D  = 2'd1,
    EXP_J0 = 2'd2,
    EXP_J1 = 2'd3
  } state_t;

  state_t     state;
  logic       stg_a;
  logic [6:0] stg_bob;
  logic [4:0] stg_j0;

  logic accept;
  logic hit;
  logic restart;
  logic bad;
  logic done;

  // Only the completing beat has to wait for the hold register.
  assign in_ready = (state != EXP_J1) | ~out_valid | out_ready;

  assign accept  = in_valid & in_ready;
  // The state encoding equals the expected tag.
  assign hit     = accept & (in_hdr == state);
  assign restart = accept & ~hit & (in_hdr == 2'd0);
  assign bad     = accept & ~hit & (in_hdr != 2'd0);
  assign done    = hit & (state == EXP_J1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EXP_A;
      stg_a   <= 1'b0;
      stg_bob <= '0;
      stg_j0  <= '0;
    end else begin
      unique case (1'b1)
        hit: begin
          unique case (state)
            EXP_A: begin
              stg_a <= in_data[0];
              state <= EXP_D;
            end
            EXP_D: begin
              stg_bob <= in_data;
              state   <= EXP_J0;
            end
            EXP_J0: begin
              stg_j0 <= in_data[4:0];
              state  <= EXP_J1;
            end
            EXP_J1: begin
              state <= EXP_A;
            end
            default: state <= EXP_A;
          endcase
        end
        restart: begin
          stg_a <= in_data[0];
          state <= EXP_D;
        end
        bad: begin
          state <= EXP_A;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (done) begin
        out_valid <= 1'b1;
        out_data  <= {stg_a, stg_bob, in_data[4:0], stg_j0};
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= restart | bad;
      if ((restart | bad) && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e_nested_assembler.sv
// tb_e_nested_assembler: directed frames plus random beats
// against a frame-level reference model.
module tb_e_nested_assembler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_hdr;
  logic [6:0]  in_data;
  logic        out_ready;

  logic        rdy_a, ov_a, ep_a;
  logic [17:0] od_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, ov_b, ep_b;
  logic [17:0] od_b;
  logic [1:0]  cnt_b;

  int n_cmp;
  int n_bad;

  // reference model
  int          m_exp;
  logic        m_a;
  logic [6:0]  m_bob;
  logic [4:0]  m_j0;
  logic        m_ov;
  logic [17:0] m_od;
  logic        m_ep;
  int          m_cnt8;
  int          m_cnt2;

  e_nested_assembler u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_a),
    .in_hdr(in_hdr), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .err_pulse(ep_a),
    .err_count(cnt_a)
  );

  e_nested_assembler #(.ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_b),
    .in_hdr(in_hdr), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .err_pulse(ep_b),
    .err_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready();
    return (m_exp != 3) || !m_ov || out_ready;
  endfunction

  task automatic model_reset();
    m_exp  = 0;
    m_a    = 1'b0;
    m_bob  = '0;
    m_j0   = '0;
    m_ov   = 1'b0;
    m_od   = '0;
    m_ep   = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_err();
    m_ep = 1'b1;
    if (m_cnt8 < 255) m_cnt8++;
    if (m_cnt2 < 3) m_cnt2++;
  endtask

  task automatic model_step();
    logic acc;
    acc  = in_valid && m_ready();
    m_ep = 1'b0;
    if (m_ov && out_ready) m_ov = 1'b0;
    if (acc) begin
      if (int'(in_hdr) == m_exp) begin
        case (m_exp)
          0: m_a = in_data[0];
          1: m_bob = in_data;
          2: m_j0 = in_data[4:0];
          default: begin
            m_ov = 1'b1;
            m_od = {m_a, m_bob, in_data[4:0], m_j0};
          end
        endcase
        m_exp = (m_exp + 1) % 4;
      end else if (in_hdr == 2'd0) begin
        model_err();
        m_a   = in_data[0];
        m_exp = 1;
      end else begin
        model_err();
        m_exp = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("in_ready", 32'(rdy_a), 32'(m_ready()));
    chk("out_valid", 32'(ov_a), 32'(m_ov));
    if (m_ov) chk("out_data", 32'(od_a), 32'(m_od));
    chk("err_pulse", 32'(ep_a), 32'(m_ep));
    chk("err_count", 32'(cnt_a), 32'(m_cnt8));
    chk("sat_ready", 32'(rdy_b), 32'(m_ready()));
    chk("sat_valid", 32'(ov_b), 32'(m_ov));
    chk("sat_pulse", 32'(ep_b), 32'(m_ep));
    chk("sat_count", 32'(cnt_b), 32'(m_cnt2));
  endtask

  // One clock: drive, check pre-edge view, advance model.
  task automatic step(input logic v, input logic [1:0] h,
                      input logic [6:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_hdr    = h;
    in_data   = d;
    out_ready = ordy;
    #1;
    check_outs();
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(ov_a), 32'd0);
    chk("rst_data", 32'(od_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_pulse", 32'(ep_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic frame(input logic ordy);
    step(1, 2'd0, 7'h01, ordy);
    step(1, 2'd1, 7'h56, ordy);
    step(1, 2'd2, 7'h0A, ordy);
    step(1, 2'd3, 7'h15, ordy);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_hdr    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    do_reset();

    // basic frame
    frame(1'b1);
    settle();
    chk("f1_valid", 32'(ov_a), 32'd1);
    chk("f1_data", 32'(od_a), 32'h35AAA);
    chk("f1_count", 32'(cnt_a), 32'd0);
    step(0, 2'd0, 7'h00, 1'b1);

    // held output, second frame stalls on J1
    do_reset();
    frame(1'b0);
    step(1, 2'd0, 7'h00, 1'b0);
    step(1, 2'd1, 7'h11, 1'b0);
    step(1, 2'd2, 7'h1F, 1'b0);
    step(1, 2'd3, 7'h03, 1'b0);
    chk("stall_ready", 32'(rdy_a), 32'd0);
    chk("stall_data", 32'(od_a), 32'h35AAA);
    step(1, 2'd3, 7'h03, 1'b1);
    settle();
    chk("f2_valid", 32'(ov_a), 32'd1);
    chk("f2_data", 32'(od_a),
        32'({1'b0, 7'h11, 5'h03, 5'h1F}));
    step(0, 2'd0, 7'h00, 1'b1);

    // restart mid-frame
    do_reset();
    step(1, 2'd0, 7'h00, 1'b1);
    step(1, 2'd1, 7'h7F, 1'b1);
    step(1, 2'd0, 7'h01, 1'b1);
    settle();
    chk("rs_pulse", 32'(ep_a), 32'd1);
    step(1, 2'd1, 7'h22, 1'b1);
    step(1, 2'd2, 7'h05, 1'b1);
    step(1, 2'd3, 7'h0C, 1'b1);
    settle();
    chk("rs_data", 32'(od_a),
        32'({1'b1, 7'h22, 5'h0C, 5'h05}));
    chk("rs_count", 32'(cnt_a), 32'd1);
    step(0, 2'd0, 7'h00, 1'b1);

    // two errors, no output
    do_reset();
    step(1, 2'd2, 7'h00, 1'b1);
    step(1, 2'd0, 7'h00, 1'b1);
    step(1, 2'd3, 7'h00, 1'b1);
    settle();
    chk("e2_count", 32'(cnt_a), 32'd2);
    chk("e2_valid", 32'(ov_a), 32'd0);
    step(0, 2'd0, 7'h00, 1'b1);

    // narrow counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 2'd1, 7'h00, 1'b1);
      settle();
      chk("sat_seq", 32'(cnt_b), 32'((i < 3) ? i + 1 : 3));
      chk("sat_pls", 32'(ep_b), 32'd1);
    end

    // reset mid-frame
    do_reset();
    step(1, 2'd0, 7'h01, 1'b1);
    step(1, 2'd1, 7'h56, 1'b1);
    do_reset();
    step(1, 2'd2, 7'h0A, 1'b1);
    step(1, 2'd3, 7'h15, 1'b1);
    settle();
    chk("mr_count", 32'(cnt_a), 32'd2);
    chk("mr_valid", 32'(ov_a), 32'd0);
    frame(1'b1);
    settle();
    chk("mr_data", 32'(od_a), 32'h35AAA);

    // wide counter saturation
    for (int i = 0; i < 300; i++) step(1, 2'd2, 7'h00, 1'b1);
    settle();
    chk("sat8", 32'(cnt_a), 32'd255);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] h;
      h = ($urandom_range(0, 3) != 0) ? 2'(m_exp)
                                      : 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, h,
           7'($urandom), $urandom_range(0, 9) < 6);
    end
    step(0, 2'd0, 7'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
